// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: bundles the command/status handshake and the
// single-port memory bus used by the copy engine.
//   master : engine side (drives status and memory address/data/we)
//   slave  : control + memory side (drives command fields and mem_rdata)
interface mem_copy_engine_if #(
    parameter int WORD_SIZE = 8,
    parameter int LEN_LOG_2 = 16
);
    // command / status
    logic                 start;
    logic                 fill_mode;
    logic [LEN_LOG_2-1:0] src_addr;
    logic [LEN_LOG_2-1:0] dst_addr;
    logic [LEN_LOG_2-1:0] length;
    logic [WORD_SIZE-1:0] fill_value;
    logic                 busy;
    logic                 done;
    logic                 error;
    // memory port
    logic [LEN_LOG_2-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport master (
        input  start, fill_mode, src_addr, dst_addr, length, fill_value, mem_rdata,
        output busy, done, error, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output start, fill_mode, src_addr, dst_addr, length, fill_value, mem_rdata,
        input  busy, done, error, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: bus initiator performing block copy (memmove semantics)
// or block fill on a single-port memory with combinational read.
//   clk    : clock, all state changes on posedge
//   reset  : synchronous active-high reset
//   bus    : mem_copy_engine_if.master
//            start/fill_mode/src_addr/dst_addr/length/fill_value in,
//            busy/done/error out, mem_addr/mem_wdata/mem_we out, mem_rdata in
// A copy moves one word per READ+WRITE cycle pair; a fill writes one word
// per cycle. Out-of-range requests and zero-length requests finish in a
// single DONE cycle without touching memory.
module mem_copy_engine #(
    parameter int WORD_SIZE = 8,
    parameter int LEN       = 65000,
    parameter int LEN_LOG_2 = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_copy_engine_if.master bus
);
    localparam int AW = LEN_LOG_2;
    // Range limits are compared one bit wider so base+length cannot overflow.
    localparam logic [AW:0] LEN_X = (AW+1)'(LEN);
    localparam logic [AW-1:0] ONE  = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FILL,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]        src_cur;
    logic [AW-1:0]        dst_cur;
    logic [AW-1:0]        cnt;
    logic [WORD_SIZE-1:0] hold;
    logic [WORD_SIZE-1:0] fill_val;
    logic                 err_q;
    logic                 desc_q;

    // ------------------------------------------------------------------
    // Accept-time decode, evaluated on the live inputs while IDLE.
    // ------------------------------------------------------------------
    logic [AW:0] dst_end;
    logic [AW:0] src_end;
    logic        range_err;
    logic        go_desc;
    logic        len_zero;
    logic        last;

    assign dst_end   = {1'b0, bus.dst_addr} + {1'b0, bus.length};
    assign src_end   = {1'b0, bus.src_addr} + {1'b0, bus.length};
    assign range_err = (dst_end > LEN_X) || (!bus.fill_mode && (src_end > LEN_X));
    // Destination starts inside the source window above its base: walking
    // upward would overwrite source words before they are read.
    assign go_desc   = !bus.fill_mode && (bus.dst_addr > bus.src_addr) &&
                       ({1'b0, bus.dst_addr} < src_end);
    assign len_zero  = (bus.length == '0);
    assign last      = (cnt == ONE);

    function automatic logic [AW-1:0] step(input logic [AW-1:0] cur, input logic dn);
        return dn ? cur - ONE : cur + ONE;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next state and outputs, decoded from registered state and cursors
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.error     = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (range_err || len_zero) state_nxt = S_DONE;
                    else if (bus.fill_mode)    state_nxt = S_FILL;
                    else                       state_nxt = S_READ;
                end
            end
            S_READ: begin
                bus.busy     = 1'b1;
                bus.mem_addr = src_cur;
                state_nxt    = S_WRITE;
            end
            S_WRITE: begin
                bus.busy      = 1'b1;
                bus.mem_addr  = dst_cur;
                bus.mem_wdata = hold;
                bus.mem_we    = 1'b1;
                state_nxt     = last ? S_DONE : S_READ;
            end
            S_FILL: begin
                bus.busy      = 1'b1;
                bus.mem_addr  = dst_cur;
                bus.mem_wdata = fill_val;
                bus.mem_we    = 1'b1;
                state_nxt     = last ? S_DONE : S_FILL;
            end
            S_DONE: begin
                bus.done  = 1'b1;
                bus.error = err_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: cursors, remaining count, read hold, latched request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            src_cur  <= '0;
            dst_cur  <= '0;
            cnt      <= '0;
            hold     <= '0;
            fill_val <= '0;
            err_q    <= 1'b0;
            desc_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Descending walks start at the top word of each block.
                        src_cur  <= go_desc ? bus.src_addr + bus.length - ONE : bus.src_addr;
                        dst_cur  <= go_desc ? bus.dst_addr + bus.length - ONE : bus.dst_addr;
                        cnt      <= bus.length;
                        fill_val <= bus.fill_value;
                        err_q    <= range_err;
                        desc_q   <= go_desc;
                    end
                end
                S_READ: hold <= bus.mem_rdata;
                S_WRITE: begin
                    cnt <= cnt - ONE;
                    // Cursors hold on the final word so they never step past
                    // the block edge (e.g. below address 0 on a descending copy).
                    if (!last) begin
                        src_cur <= step(src_cur, desc_q);
                        dst_cur <= step(dst_cur, desc_q);
                    end
                end
                S_FILL: begin
                    cnt <= cnt - ONE;
                    if (!last) dst_cur <= dst_cur + ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed test-plan steps followed
// by randomized copy/fill requests, each checked against a memmove/fill model.
module tb_mem_copy_engine;
    localparam int WS  = 8;
    localparam int LEN = 65000;
    localparam int AW  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_copy_engine_if #(.WORD_SIZE(WS), .LEN_LOG_2(AW)) bus ();

    mem_copy_engine #(.WORD_SIZE(WS), .LEN(LEN), .LEN_LOG_2(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: combinational read, write on posedge. A preload port
    // lets the bench seed contents while the engine is idle.
    logic [WS-1:0] mem [0:LEN-1];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [WS-1:0] pl_data;

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Write log: every engine write is appended; ops read from a base index.
    logic [AW-1:0] wlog_a [0:8191];
    logic [WS-1:0] wlog_d [0:8191];
    int            wlog_n = 0;
    int            we_bad = 0;

    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr]      <= bus.mem_wdata;
            wlog_a[wlog_n % 8192]  <= bus.mem_addr;
            wlog_d[wlog_n % 8192]  <= bus.mem_wdata;
            wlog_n                 <= wlog_n + 1;
        end
        if (bus.mem_we && !bus.busy) we_bad <= we_bad + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pl(input int a, input int v);
        pl_we   = 1'b1;
        pl_addr = AW'(a);
        pl_data = WS'(v);
        @(posedge clk); #1;
        pl_we   = 1'b0;
    endtask

    task automatic scramble();
        bus.fill_mode  = 1'($urandom);
        bus.src_addr   = AW'($urandom);
        bus.dst_addr   = AW'($urandom);
        bus.length     = AW'($urandom);
        bus.fill_value = WS'($urandom);
    endtask

    // Issue one request and check it. Caller sits 1 time unit after a posedge.
    // poke >= 0 raises start with unrelated arguments on that busy cycle.
    task automatic run_op(input bit fm, input int s, input int d, input int l,
                          input int fv, input int poke);
        logic [AW-1:0] ea [$];
        logic [WS-1:0] ed [$];
        logic [WS-1:0] tmp [$];
        bit  eerr, desc;
        int  ecyc, base, cyc, n, idx;

        // Reference: range rule, memmove write order, fill pattern.
        eerr = (d + l > LEN) || (!fm && (s + l > LEN));
        if (!eerr && l != 0) begin
            if (fm) begin
                for (int i = 0; i < l; i++) begin
                    ea.push_back(AW'(d + i));
                    ed.push_back(WS'(fv));
                end
            end else begin
                for (int i = 0; i < l; i++) tmp.push_back(mem[s + i]);
                desc = (d > s) && (d < s + l);
                for (int k = 0; k < l; k++) begin
                    idx = desc ? l - 1 - k : k;
                    ea.push_back(AW'(d + idx));
                    ed.push_back(tmp[idx]);
                end
            end
        end
        ecyc = (eerr || l == 0) ? 0 : (fm ? l : 2 * l);

        bus.fill_mode  = fm;
        bus.src_addr   = AW'(s);
        bus.dst_addr   = AW'(d);
        bus.length     = AW'(l);
        bus.fill_value = WS'(fv);
        bus.start      = 1'b1;
        base = wlog_n;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();

        cyc = 0;
        while (bus.busy && cyc < ecyc + 8) begin
            bus.start = (cyc == poke);
            if (cyc == poke) scramble();
            cyc++;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;

        chk("busy_cycles", cyc, ecyc);
        chk("done_high", bus.done, 1'b1);
        chk("error_flag", bus.error, eerr);
        chk("busy_in_done", bus.busy, 1'b0);
        n = wlog_n - base;
        chk("write_count", n, ea.size());
        for (int k = 0; k < ea.size() && k < n; k++) begin
            chk("write_addr", wlog_a[(base + k) % 8192], ea[k]);
            chk("write_data", wlog_d[(base + k) % 8192], ed[k]);
            chk("mem_final", mem[ea[k]], ed[k]);
        end
        @(posedge clk); #1;
        chk("done_single", bus.done, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WS-1:0] rtmp [0:3];
        logic [WS-1:0] old402;
        int base, s, d, l, mode;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.fill_mode  = 1'b0;
        bus.src_addr   = '0;
        bus.dst_addr   = '0;
        bus.length     = '0;
        bus.fill_value = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_we",    bus.mem_we, 0);
        chk("rst_addr",  bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        reset = 1'b0;

        for (int i = 0; i < 600; i++) pl(i, $urandom);
        for (int i = 64900; i < LEN; i++) pl(i, $urandom);

        // Ascending copy
        pl(100, 11); pl(101, 22); pl(102, 33); pl(103, 44);
        run_op(0, 100, 200, 4, 0, -1);
        chk("asc_200", mem[200], 11);
        chk("asc_203", mem[203], 44);

        // Overlapping descending copy
        for (int i = 0; i < 5; i++) pl(10 + i, i + 1);
        run_op(0, 10, 12, 5, 0, -1);
        chk("ovl_12", mem[12], 1);
        chk("ovl_16", mem[16], 5);

        // Fill up to the last address
        run_op(1, 0, 64990, 10, 8'hA5, -1);
        chk("fill_last", mem[LEN-1], 8'hA5);

        // Source range error, zero length, fill dst range error
        run_op(0, 64995, 0, 6, 0, -1);
        run_op(0, 20, 40, 0, 0, -1);
        run_op(1, 0, 64995, 6, 8'h3C, -1);

        // Start while busy is ignored
        run_op(0, 100, 300, 4, 0, 3);

        // Reset mid-copy on the 5th busy cycle
        for (int i = 0; i < 4; i++) rtmp[i] = mem[300 + i];
        old402 = mem[402];
        bus.fill_mode = 1'b0; bus.src_addr = 300; bus.dst_addr = 400; bus.length = 4;
        bus.start = 1'b1;
        base = wlog_n;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst5_busy", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstm_busy",  bus.busy, 0);
        chk("rstm_we",    bus.mem_we, 0);
        chk("rstm_done",  bus.done, 0);
        chk("rstm_error", bus.error, 0);
        chk("rstm_writes", wlog_n - base, 2);
        chk("rstm_400", mem[400], rtmp[0]);
        chk("rstm_401", mem[401], rtmp[1]);
        chk("rstm_402", mem[402], old402);
        reset = 1'b0;
        run_op(0, 400, 450, 3, 0, -1);

        // Randomized requests
        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(0, 3);
            s = $urandom_range(0, 560);
            l = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) begin
                d = s + $urandom_range(0, 16) - 8;
                if (d < 0) d = 0;
            end else begin
                d = $urandom_range(0, 560);
            end
            if ($urandom_range(0, 7) == 0) d = 64985 + $urandom_range(0, 14);
            if ($urandom_range(0, 7) == 0) s = 64985 + $urandom_range(0, 14);
            run_op(mode == 0, s, d, l, $urandom, -1);
        end

        chk("we_only_busy", we_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
